// File: rtl/soc_mem_arbiter.sv
`default_nettype none
// ============================================================================
// soc_mem_arbiter : two-master Avalon-MM arbiter in front of one 1-cycle RAM
// Revision 1.0
// ============================================================================
module soc_mem_arbiter #(
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 16,
    parameter int BE_W       = DATA_W / 8,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] ram_address,
    output logic [BE_W-1:0]   ram_byteenable,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_writedata,
    output logic              ram_clken,
    input  logic [DATA_W-1:0] ram_readdata
);

    logic              w_req0;
    logic              w_req1;
    logic              w_grant0;
    logic              w_grant1;
    logic              w_any;
    logic              w_is_write;
    logic [ADDR_W-1:0] w_addr;
    logic [BE_W-1:0]   w_be;
    logic [DATA_W-1:0] w_wdata;

    logic              r_last_m1;
    logic              r_s1_valid;
    logic              r_s1_id;
    logic              r_s2_valid;
    logic              r_s2_id;

    assign w_req0 = m0_read | m0_write;
    assign w_req1 = m1_read | m1_write;

    // Reset is folded in so both masters see waitrequest while it is held.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (!hold && !reset) begin
            if (w_req0 && !w_req1) begin
                w_grant0 = 1'b1;
            end else if (w_req1 && !w_req0) begin
                w_grant1 = 1'b1;
            end else if (w_req0 && w_req1) begin
                if ((FIXED_PRIO != 0) || r_last_m1) begin
                    w_grant0 = 1'b1;
                end else begin
                    w_grant1 = 1'b1;
                end
            end
        end
    end

    assign w_any          = w_grant0 | w_grant1;
    assign m0_waitrequest = ~w_grant0;
    assign m1_waitrequest = ~w_grant1;
    assign w_is_write     = w_grant1 ? m1_write      : m0_write;
    assign w_addr         = w_grant1 ? m1_address    : m0_address;
    assign w_be           = w_grant1 ? m1_byteenable : m0_byteenable;
    assign w_wdata        = w_grant1 ? m1_writedata  : m0_writedata;
    assign ram_clken      = 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_address      <= '0;
            ram_byteenable   <= '0;
            ram_writedata    <= '0;
            ram_chipselect   <= 1'b0;
            ram_write        <= 1'b0;
            r_last_m1        <= 1'b1;
            r_s1_valid       <= 1'b0;
            r_s1_id          <= 1'b0;
            r_s2_valid       <= 1'b0;
            r_s2_id          <= 1'b0;
            m0_readdata      <= '0;
            m1_readdata      <= '0;
            m0_readdatavalid <= 1'b0;
            m1_readdatavalid <= 1'b0;
        end else begin
            ram_chipselect <= w_any;
            ram_write      <= w_any & w_is_write;
            if (w_any) begin
                ram_address    <= w_addr;
                ram_byteenable <= w_be;
                ram_writedata  <= w_wdata;
                r_last_m1      <= w_grant1;
            end

            // Read tracker: stage 1 follows the RAM address, stage 2 the RAM data.
            r_s1_valid <= w_any & ~w_is_write;
            r_s1_id    <= w_grant1;
            r_s2_valid <= r_s1_valid;
            r_s2_id    <= r_s1_id;

            m0_readdatavalid <= r_s2_valid & ~r_s2_id;
            m1_readdatavalid <= r_s2_valid & r_s2_id;
            if (r_s2_valid && !r_s2_id) begin
                m0_readdata <= ram_readdata;
            end
            if (r_s2_valid && r_s2_id) begin
                m1_readdata <= ram_readdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_soc_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_soc_mem_arbiter : directed bench for soc_mem_arbiter with a RAM model
// Revision 1.0
// ============================================================================
module tb_soc_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        hold;

    logic [6:0]  a_m0_address,  a_m1_address;
    logic [1:0]  a_m0_byteenable, a_m1_byteenable;
    logic        a_m0_read, a_m0_write, a_m1_read, a_m1_write;
    logic [15:0] a_m0_writedata, a_m1_writedata;
    logic        a_m0_waitrequest, a_m1_waitrequest;
    logic [15:0] a_m0_readdata, a_m1_readdata;
    logic        a_m0_readdatavalid, a_m1_readdatavalid;
    logic [6:0]  a_ram_address;
    logic [1:0]  a_ram_byteenable;
    logic        a_ram_chipselect, a_ram_write, a_ram_clken;
    logic [15:0] a_ram_writedata;
    logic [15:0] a_ram_readdata;

    logic        b_m0_read, b_m1_read;
    logic        b_m0_waitrequest, b_m1_waitrequest;
    logic [15:0] b_m0_readdata, b_m1_readdata;
    logic        b_m0_readdatavalid, b_m1_readdatavalid;
    logic [6:0]  b_ram_address;
    logic [1:0]  b_ram_byteenable;
    logic        b_ram_chipselect, b_ram_write, b_ram_clken;
    logic [15:0] b_ram_writedata;
    logic [15:0] b_ram_readdata;

    logic [15:0] mem_a [0:127];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    soc_mem_arbiter #(.ADDR_W(7), .DATA_W(16), .BE_W(2), .FIXED_PRIO(0)) u_dut_rr (
        .clk(clk), .reset(reset), .hold(hold),
        .m0_address(a_m0_address), .m0_byteenable(a_m0_byteenable),
        .m0_read(a_m0_read), .m0_write(a_m0_write), .m0_writedata(a_m0_writedata),
        .m0_waitrequest(a_m0_waitrequest), .m0_readdata(a_m0_readdata),
        .m0_readdatavalid(a_m0_readdatavalid),
        .m1_address(a_m1_address), .m1_byteenable(a_m1_byteenable),
        .m1_read(a_m1_read), .m1_write(a_m1_write), .m1_writedata(a_m1_writedata),
        .m1_waitrequest(a_m1_waitrequest), .m1_readdata(a_m1_readdata),
        .m1_readdatavalid(a_m1_readdatavalid),
        .ram_address(a_ram_address), .ram_byteenable(a_ram_byteenable),
        .ram_chipselect(a_ram_chipselect), .ram_write(a_ram_write),
        .ram_writedata(a_ram_writedata), .ram_clken(a_ram_clken),
        .ram_readdata(a_ram_readdata)
    );

    soc_mem_arbiter #(.ADDR_W(7), .DATA_W(16), .BE_W(2), .FIXED_PRIO(1)) u_dut_fp (
        .clk(clk), .reset(reset), .hold(1'b0),
        .m0_address(7'h03), .m0_byteenable(2'b11),
        .m0_read(b_m0_read), .m0_write(1'b0), .m0_writedata(16'h0000),
        .m0_waitrequest(b_m0_waitrequest), .m0_readdata(b_m0_readdata),
        .m0_readdatavalid(b_m0_readdatavalid),
        .m1_address(7'h04), .m1_byteenable(2'b11),
        .m1_read(b_m1_read), .m1_write(1'b0), .m1_writedata(16'h0000),
        .m1_waitrequest(b_m1_waitrequest), .m1_readdata(b_m1_readdata),
        .m1_readdatavalid(b_m1_readdatavalid),
        .ram_address(b_ram_address), .ram_byteenable(b_ram_byteenable),
        .ram_chipselect(b_ram_chipselect), .ram_write(b_ram_write),
        .ram_writedata(b_ram_writedata), .ram_clken(b_ram_clken),
        .ram_readdata(b_ram_readdata)
    );

    assign b_ram_readdata = 16'h0000;

    // Single-port RAM model: one-cycle registered read, byte-lane writes.
    always @(posedge clk) begin
        if (a_ram_chipselect) begin
            if (a_ram_write) begin
                if (a_ram_byteenable[0]) mem_a[a_ram_address][7:0]  <= a_ram_writedata[7:0];
                if (a_ram_byteenable[1]) mem_a[a_ram_address][15:8] <= a_ram_writedata[15:8];
            end else begin
                a_ram_readdata <= mem_a[a_ram_address];
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_a;
        a_m0_read = 0; a_m0_write = 0; a_m1_read = 0; a_m1_write = 0;
    endtask

    task automatic test_reset;
        a_m0_read = 1; a_m0_address = 7'h05;
        #2;
        n_cmp++; if (a_m0_waitrequest !== 1'b1) begin n_err++; $display("FAIL reset_wait0: got %b want 1", a_m0_waitrequest); end
        n_cmp++; if (a_m1_waitrequest !== 1'b1) begin n_err++; $display("FAIL reset_wait1: got %b want 1", a_m1_waitrequest); end
        n_cmp++; if (a_ram_chipselect !== 1'b0) begin n_err++; $display("FAIL reset_cs: got %b want 0", a_ram_chipselect); end
        n_cmp++; if (a_m0_readdatavalid !== 1'b0) begin n_err++; $display("FAIL reset_rdv0: got %b want 0", a_m0_readdatavalid); end
        n_cmp++; if (a_m0_readdata !== 16'h0000) begin n_err++; $display("FAIL reset_rd0: got %h want 0000", a_m0_readdata); end
        n_cmp++; if (a_ram_address !== 7'h00) begin n_err++; $display("FAIL reset_addr: got %h want 00", a_ram_address); end
        a_m0_read = 0;
        step; step;
        reset = 0;
    endtask

    task automatic test_write_read;
        a_m0_write = 1; a_m0_address = 7'h05; a_m0_writedata = 16'hA55A; a_m0_byteenable = 2'b11;
        #1;
        n_cmp++; if (a_m0_waitrequest !== 1'b0) begin n_err++; $display("FAIL wr_wait: got %b want 0", a_m0_waitrequest); end
        step;
        a_m0_write = 0; a_m0_read = 1;
        #1;
        n_cmp++; if (a_m0_waitrequest !== 1'b0) begin n_err++; $display("FAIL rd_wait: got %b want 0", a_m0_waitrequest); end
        n_cmp++; if ({a_ram_chipselect, a_ram_write, a_ram_address, a_ram_writedata} !== {2'b11, 7'h05, 16'hA55A})
            begin n_err++; $display("FAIL wr_cmd: got cs=%b we=%b a=%h d=%h want 1 1 05 a55a", a_ram_chipselect, a_ram_write, a_ram_address, a_ram_writedata); end
        step;
        a_m0_read = 0;
        #1;
        n_cmp++; if (a_m0_readdatavalid !== 1'b0) begin n_err++; $display("FAIL rd_early1: got %b want 0", a_m0_readdatavalid); end
        step;
        n_cmp++; if (a_m0_readdatavalid !== 1'b0) begin n_err++; $display("FAIL rd_early2: got %b want 0", a_m0_readdatavalid); end
        step;
        n_cmp++; if (a_m0_readdatavalid !== 1'b1) begin n_err++; $display("FAIL rd_valid: got %b want 1", a_m0_readdatavalid); end
        n_cmp++; if (a_m0_readdata !== 16'hA55A) begin n_err++; $display("FAIL rd_data: got %h want a55a", a_m0_readdata); end
        n_cmp++; if (a_m1_readdatavalid !== 1'b0) begin n_err++; $display("FAIL rd_other: got %b want 0", a_m1_readdatavalid); end
        step;
        n_cmp++; if (a_m0_readdatavalid !== 1'b0) begin n_err++; $display("FAIL rd_strobe: got %b want 0", a_m0_readdatavalid); end
    endtask

    task automatic test_partial_write;
        a_m1_write = 1; a_m1_address = 7'h10; a_m1_writedata = 16'h1234; a_m1_byteenable = 2'b11;
        #1;
        n_cmp++; if (a_m1_waitrequest !== 1'b0) begin n_err++; $display("FAIL pw_wait1: got %b want 0", a_m1_waitrequest); end
        step;
        a_m1_writedata = 16'hFF00; a_m1_byteenable = 2'b10;
        #1;
        n_cmp++; if (a_m1_waitrequest !== 1'b0) begin n_err++; $display("FAIL pw_wait2: got %b want 0", a_m1_waitrequest); end
        step;
        a_m1_write = 0; a_m1_read = 1;
        #1;
        n_cmp++; if (a_ram_byteenable !== 2'b10) begin n_err++; $display("FAIL pw_be: got %b want 10", a_ram_byteenable); end
        step;
        a_m1_read = 0;
        step; step;
        n_cmp++; if (a_m1_readdatavalid !== 1'b1) begin n_err++; $display("FAIL pw_valid: got %b want 1", a_m1_readdatavalid); end
        n_cmp++; if (a_m1_readdata !== 16'hFF34) begin n_err++; $display("FAIL pw_data: got %h want ff34", a_m1_readdata); end
        n_cmp++; if (a_m0_readdatavalid !== 1'b0) begin n_err++; $display("FAIL pw_m0rdv: got %b want 0", a_m0_readdatavalid); end
        n_cmp++; if (a_m0_readdata !== 16'hA55A) begin n_err++; $display("FAIL pw_m0hold: got %h want a55a", a_m0_readdata); end
    endtask

    task automatic test_round_robin;
        a_m0_write = 1; a_m0_address = 7'h01; a_m0_writedata = 16'h1111; a_m0_byteenable = 2'b11;
        step;
        a_m0_write = 0;
        a_m1_write = 1; a_m1_address = 7'h02; a_m1_writedata = 16'h2222; a_m1_byteenable = 2'b11;
        step;
        a_m1_write = 0;
        for (int j = 0; j < 10; j++) begin
            a_m0_read = (j < 6); a_m0_address = 7'h01;
            a_m1_read = (j < 6); a_m1_address = 7'h02;
            #1;
            if (j < 6) begin
                n_cmp++; if (a_m0_waitrequest !== ((j % 2) != 0)) begin n_err++; $display("FAIL rr_wait0[%0d]: got %b want %b", j, a_m0_waitrequest, (j % 2) != 0); end
                n_cmp++; if (a_m1_waitrequest !== ((j % 2) == 0)) begin n_err++; $display("FAIL rr_wait1[%0d]: got %b want %b", j, a_m1_waitrequest, (j % 2) == 0); end
            end
            if (j >= 3 && j < 9) begin
                if (((j - 3) % 2) == 0) begin
                    n_cmp++; if ({a_m0_readdatavalid, a_m1_readdatavalid, a_m0_readdata} !== {2'b10, 16'h1111})
                        begin n_err++; $display("FAIL rr_ret0[%0d]: got v0=%b v1=%b d=%h want 1 0 1111", j, a_m0_readdatavalid, a_m1_readdatavalid, a_m0_readdata); end
                end else begin
                    n_cmp++; if ({a_m0_readdatavalid, a_m1_readdatavalid, a_m1_readdata} !== {2'b01, 16'h2222})
                        begin n_err++; $display("FAIL rr_ret1[%0d]: got v0=%b v1=%b d=%h want 0 1 2222", j, a_m0_readdatavalid, a_m1_readdatavalid, a_m1_readdata); end
                end
            end
            step;
        end
    endtask

    task automatic test_hold;
        a_m0_write = 1; a_m0_address = 7'h7F; a_m0_writedata = 16'hBEEF; a_m0_byteenable = 2'b11;
        step;
        a_m0_write = 0; a_m0_read = 1;
        #1;
        n_cmp++; if (a_m0_waitrequest !== 1'b0) begin n_err++; $display("FAIL hold_acc: got %b want 0", a_m0_waitrequest); end
        step;
        hold = 1; a_m1_read = 1; a_m1_address = 7'h02;
        for (int k = 1; k < 4; k++) begin
            #1;
            n_cmp++; if ({a_m0_waitrequest, a_m1_waitrequest} !== 2'b11) begin n_err++; $display("FAIL hold_wait[%0d]: got %b%b want 11", k, a_m0_waitrequest, a_m1_waitrequest); end
            if (k == 2) begin
                n_cmp++; if (a_ram_chipselect !== 1'b0) begin n_err++; $display("FAIL hold_cs: got %b want 0", a_ram_chipselect); end
            end
            if (k == 3) begin
                n_cmp++; if ({a_m0_readdatavalid, a_m0_readdata} !== {1'b1, 16'hBEEF}) begin n_err++; $display("FAIL hold_rd: got v=%b d=%h want 1 beef", a_m0_readdatavalid, a_m0_readdata); end
            end
            step;
        end
        hold = 0;
        #1;
        n_cmp++; if ({a_m0_waitrequest, a_m1_waitrequest} !== 2'b10) begin n_err++; $display("FAIL hold_release: got %b%b want 10", a_m0_waitrequest, a_m1_waitrequest); end
        step;
        clear_a;
        step; step;
        n_cmp++; if ({a_m1_readdatavalid, a_m1_readdata} !== {1'b1, 16'h2222}) begin n_err++; $display("FAIL hold_m1rd: got v=%b d=%h want 1 2222", a_m1_readdatavalid, a_m1_readdata); end
        step;
    endtask

    task automatic test_reset_inflight;
        a_m0_read = 1; a_m0_address = 7'h01;
        #1;
        n_cmp++; if (a_m0_waitrequest !== 1'b0) begin n_err++; $display("FAIL rst_acc: got %b want 0", a_m0_waitrequest); end
        step;
        a_m0_read = 0;
        reset = 1;
        #1;
        n_cmp++; if ({a_ram_chipselect, a_m0_waitrequest} !== 2'b01) begin n_err++; $display("FAIL rst_async: got cs=%b w=%b want 0 1", a_ram_chipselect, a_m0_waitrequest); end
        n_cmp++; if ({a_m0_readdata, a_m1_readdata} !== 32'h0) begin n_err++; $display("FAIL rst_data: got %h %h want 0 0", a_m0_readdata, a_m1_readdata); end
        step;
        reset = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++; if ({a_m0_readdatavalid, a_m1_readdatavalid} !== 2'b00) begin n_err++; $display("FAIL rst_norv[%0d]: got %b%b want 00", k, a_m0_readdatavalid, a_m1_readdatavalid); end
            step;
        end
        a_m0_read = 1; a_m1_read = 1;
        #1;
        n_cmp++; if ({a_m0_waitrequest, a_m1_waitrequest} !== 2'b01) begin n_err++; $display("FAIL rst_ptr: got %b%b want 01", a_m0_waitrequest, a_m1_waitrequest); end
        step;
        clear_a;
        step;
    endtask

    task automatic test_fixed_prio;
        for (int k = 0; k < 5; k++) begin
            b_m0_read = (k < 4); b_m1_read = 1;
            #1;
            if (k < 4) begin
                n_cmp++; if ({b_m0_waitrequest, b_m1_waitrequest} !== 2'b01) begin n_err++; $display("FAIL fp_wait[%0d]: got %b%b want 01", k, b_m0_waitrequest, b_m1_waitrequest); end
            end else begin
                n_cmp++; if (b_m1_waitrequest !== 1'b0) begin n_err++; $display("FAIL fp_m1: got %b want 0", b_m1_waitrequest); end
            end
            step;
        end
        b_m0_read = 0; b_m1_read = 0;
    endtask

    initial begin
        reset = 1; hold = 0;
        a_m0_address = '0; a_m0_byteenable = 2'b11; a_m0_writedata = '0;
        a_m1_address = '0; a_m1_byteenable = 2'b11; a_m1_writedata = '0;
        clear_a;
        b_m0_read = 0; b_m1_read = 0;
        test_reset;
        test_write_read;
        test_partial_write;
        test_round_robin;
        test_hold;
        test_reset_inflight;
        test_fixed_prio;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
